// File: rtl/mult_host.sv
// mult_host: operand-pair FIFO feeding a four-phase request/acknowledge
// handshake with an external multiplier, capturing each product in turn.
// Optional feature: define MULT_HOST_TIMEOUT_EN to abandon a request that
// sees no iDone within TIMEOUT cycles and flag it on oTimeout.
//
// state  | meaning
// IDLE   | no request open; starts one as soon as the FIFO holds an entry
// REQ    | oValid_Data high, operands held, waiting for iDone
// ACK    | oAck high, waiting for the multiplier to drop iDone
module mult_host #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iWr_En,
    input  logic [WIDTH-1:0]     iOp_A,
    input  logic [WIDTH-1:0]     iOp_B,
    input  logic                 iDone,
    input  logic [2*WIDTH-1:0]   iProduct,
    output logic                 oFull,
    output logic                 oOverflow,
    output logic                 oValid_Data,
    output logic [WIDTH-1:0]     oOp_A,
    output logic [WIDTH-1:0]     oOp_B,
    output logic                 oAck,
    output logic [2*WIDTH-1:0]   oResult,
    output logic                 oResult_Valid,
`ifdef MULT_HOST_TIMEOUT_EN
    output logic                 oTimeout,
`endif
    output logic                 oBusy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Elaboration-time guard on the parameter set.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("mult_host: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_mem_a [DEPTH];
    logic [WIDTH-1:0]     r_mem_b [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 r_overflow;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_result_valid;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load;
    logic                 w_capture;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // A push is judged against the registered full flag, so a same-edge pop
    // does not rescue a push into a full FIFO.
    assign w_push  = iWr_En && !w_full;

`ifdef MULT_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0]        r_tmo_cnt;
    logic                 r_timeout;
    logic                 w_tmo_expire;
`endif

    // Next-state and control strobes for the handshake machine.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        w_pop       = 1'b0;
`ifdef MULT_HOST_TIMEOUT_EN
        w_tmo_expire = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_REQ;
                    w_load      = 1'b1;
                end
            end
            S_REQ: begin
                if (iDone) begin
                    w_state_nxt = S_ACK;
                    w_capture   = 1'b1;
                    w_pop       = 1'b1;
                end
`ifdef MULT_HOST_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt  = S_IDLE;
                    w_tmo_expire = 1'b1;
                    w_pop        = 1'b1;
                end
`endif
            end
            S_ACK: begin
                if (!iDone) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= iOp_A;
            r_mem_b[r_wr_ptr] <= iOp_B;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (iWr_En && w_full) r_overflow <= 1'b1;
        end
    end

    // Operand presentation and product capture.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_op_a <= r_mem_a[r_rd_ptr];
                r_op_b <= r_mem_b[r_rd_ptr];
            end
            if (w_capture) r_result <= iProduct;
            r_result_valid <= w_capture;
        end
    end

`ifdef MULT_HOST_TIMEOUT_EN
    // Cycles spent in REQ since entry, plus the one-cycle timeout pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_load)                    r_tmo_cnt <= '0;
            else if (r_state == S_REQ)     r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_timeout <= w_tmo_expire;
        end
    end

    assign oTimeout = r_timeout;
`endif

    assign oFull         = w_full;
    assign oOverflow     = r_overflow;
    assign oValid_Data   = (r_state == S_REQ);
    assign oAck          = (r_state == S_ACK);
    assign oBusy         = (r_state != S_IDLE);
    assign oOp_A         = r_op_a;
    assign oOp_B         = r_op_b;
    assign oResult       = r_result;
    assign oResult_Valid = r_result_valid;

endmodule

// File: tb/tb_mult_host.sv
// Randomized bench for mult_host. The reference model is a queue of operand
// pairs plus a last-result register; the bench plays the multiplier and
// supplies the true product of the head pair.
module tb_mult_host;

    localparam int W = 16;
    localparam int D = 4;
    localparam int T = 64;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             iWr_En = 1'b0;
    logic [W-1:0]     iOp_A = '0;
    logic [W-1:0]     iOp_B = '0;
    logic             iDone = 1'b0;
    logic [2*W-1:0]   iProduct = '0;
    logic             oFull, oOverflow, oValid_Data, oAck, oResult_Valid, oBusy;
    logic [W-1:0]     oOp_A, oOp_B;
    logic [2*W-1:0]   oResult;
`ifdef MULT_HOST_TIMEOUT_EN
    logic             oTimeout;
`endif

    mult_host #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iWr_En        (iWr_En),
        .iOp_A         (iOp_A),
        .iOp_B         (iOp_B),
        .iDone         (iDone),
        .iProduct      (iProduct),
        .oFull         (oFull),
        .oOverflow     (oOverflow),
        .oValid_Data   (oValid_Data),
        .oOp_A         (oOp_A),
        .oOp_B         (oOp_B),
        .oAck          (oAck),
        .oResult       (oResult),
        .oResult_Valid (oResult_Valid),
`ifdef MULT_HOST_TIMEOUT_EN
        .oTimeout      (oTimeout),
`endif
        .oBusy         (oBusy)
    );

    always #5 Clock = ~Clock;

    pair_t          q[$];
    logic [2*W-1:0] m_result = '0;
    logic           m_ovf = 1'b0;
    int             n_vec = 0;
    int             n_err = 0;

    task automatic check_val(input string tag, input longint unsigned got,
                             input longint unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge Clock);
    endtask

    function automatic logic [2*W-1:0] prod(input pair_t p);
        return (2*W)'(p.a) * (2*W)'(p.b);
    endfunction

    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        iWr_En = 1'b1;
        iOp_A  = a;
        iOp_B  = b;
        tick();
        iWr_En = 1'b0;
        if (q.size() < D) q.push_back(p);
        else              m_ovf = 1'b1;
        check_val("push_ovf", oOverflow, m_ovf);
        check_val("push_full", oFull, q.size() == D);
    endtask

    // Serve the head entry: wait for the request, answer after `delay`
    // cycles, keep iDone high `hold` extra cycles, optionally push on the
    // capture edge.
    task automatic serve(input int delay, input int hold, input bit do_push,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bit full_before;
        pair_t p;
        logic [2*W-1:0] exp_p;
        while (!oValid_Data && n < 20) begin
            tick();
            n++;
        end
        if (!oValid_Data) begin
            check_val("req_wait", 0, 1);
            return;
        end
        if (q.size() == 0) begin
            check_val("spurious_req", 1, 0);
            return;
        end
        check_val("op_a", oOp_A, q[0].a);
        check_val("op_b", oOp_B, q[0].b);
        repeat (delay) tick();
        check_val("req_held", oValid_Data, 1);
        check_val("op_a_stable", oOp_A, q[0].a);
        exp_p    = prod(q[0]);
        iDone    = 1'b1;
        iProduct = exp_p;
        if (do_push) begin
            iWr_En = 1'b1;
            iOp_A  = a;
            iOp_B  = b;
        end
        full_before = (q.size() == D);
        tick();
        iWr_En = 1'b0;
        void'(q.pop_front());
        if (do_push) begin
            p.a = a;
            p.b = b;
            if (!full_before) q.push_back(p);
            else              m_ovf = 1'b1;
        end
        m_result = exp_p;
        check_val("ack_up", oAck, 1);
        check_val("req_down", oValid_Data, 0);
        check_val("rv_pulse", oResult_Valid, 1);
        check_val("result", oResult, m_result);
        check_val("ovf", oOverflow, m_ovf);
        check_val("full", oFull, q.size() == D);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_val("ack_hold", oAck, 1);
            check_val("rv_single", oResult_Valid, 0);
        end
        iDone    = 1'b0;
        iProduct = $urandom();
        tick();
        check_val("ack_down", oAck, 0);
        check_val("idle_busy", oBusy, 0);
        check_val("result_kept", oResult, m_result);
        if (q.size() > 0) begin
            tick();
            check_val("b2b_req", oValid_Data, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, oValid_Data, 0);
        check_val({tag, "_ack"}, oAck, 0);
        check_val({tag, "_ops"}, {oOp_A, oOp_B}, 0);
        check_val({tag, "_result"}, oResult, 0);
        check_val({tag, "_rv"}, oResult_Valid, 0);
        check_val({tag, "_ovf"}, oOverflow, 0);
        check_val({tag, "_full"}, oFull, 0);
        check_val({tag, "_busy"}, oBusy, 0);
`ifdef MULT_HOST_TIMEOUT_EN
        check_val({tag, "_tmo"}, oTimeout, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_all_zero("rst");
        tick();
        Reset = 1'b1;
        tick();

        // iDone while idle and empty is ignored.
        iDone = 1'b1;
        iProduct = 32'h1234_5678;
        tick();
        tick();
        check_val("idle_done_ack", oAck, 0);
        check_val("idle_done_busy", oBusy, 0);
        iDone = 1'b0;
        tick();
        check_val("idle_done_result", oResult, 0);
        check_val("idle_done_rv", oResult_Valid, 0);

        // 3 x 5 with latency check and an 8-cycle multiplier.
        push_pair(16'd3, 16'd5);
        check_val("lat_write_edge", oValid_Data, 0);
        tick();
        check_val("lat_load_edge", oValid_Data, 1);
        serve(8, 2, 1'b0, '0, '0);
        check_val("r032_result", oResult, 32'd15);

        // Full-scale operands, no truncation.
        push_pair(16'hFFFF, 16'hFFFF);
        serve(3, 0, 1'b0, '0, '0);
        check_val("r034_result", oResult, 32'hFFFE_0001);

        // Fill past capacity, then drain in order.
        for (int i = 0; i < 5; i++) push_pair(W'($urandom()), W'($urandom()));
        check_val("r033_full", oFull, 1);
        check_val("r033_ovf", oOverflow, 1);
        for (int i = 0; i < 4; i++) serve($urandom_range(0, 4), $urandom_range(0, 2), 1'b0, '0, '0);
        check_val("r033_drained", q.size(), 0);
        repeat (3) tick();
        check_val("r033_no_req", oValid_Data, 0);

        // Random traffic with occasional same-edge push/pop.
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) push_pair(W'($urandom()), W'($urandom()));
            if (q.size() > 0)
                serve($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      W'($urandom()), W'($urandom()));
        end
        while (q.size() > 0) serve($urandom_range(0, 3), 0, 1'b0, '0, '0);

        // Reset in ACK with two pairs still queued.
        for (int i = 0; i < 3; i++) push_pair(W'($urandom()), W'($urandom()));
        begin
            int n = 0;
            while (!oValid_Data && n < 20) begin
                tick();
                n++;
            end
        end
        check_val("r035_req", oValid_Data, 1);
        iDone = 1'b1;
        iProduct = prod(q[0]);
        tick();
        check_val("r035_in_ack", oAck, 1);
        #2 Reset = 1'b0;
        #1 check_all_zero("r035");
        iDone = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_result = '0;
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("r035_quiet", oValid_Data, 0);
        end
        push_pair(16'd7, 16'd9);
        serve(1, 0, 1'b0, '0, '0);

`ifdef MULT_HOST_TIMEOUT_EN
        // Unanswered request times out, next entry still served.
        push_pair(W'($urandom()), W'($urandom()));
        push_pair(16'd11, 16'd13);
        begin
            int n = 0;
            bit saw_ack = 1'b0;
            while (!oValid_Data && n < 20) begin
                tick();
                n++;
            end
            check_val("tmo_req", oValid_Data, 1);
            n = 0;
            while (!oTimeout && n < 200) begin
                tick();
                n++;
                if (oAck) saw_ack = 1'b1;
            end
            check_val("tmo_cycles", n, T);
            check_val("tmo_no_ack", saw_ack, 0);
            check_val("tmo_req_drop", oValid_Data, 0);
            check_val("tmo_result_kept", oResult, m_result);
            void'(q.pop_front());
            tick();
            check_val("tmo_single", oTimeout, 0);
        end
        serve(2, 1, 1'b0, '0, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_host.md
MULT_HOST -- requirements
Module: mult_host

Interface
REQ-001 Parameter WIDTH, default 16: operand width; product width is 2*WIDTH.
REQ-002 Parameter DEPTH, default 4: operand-pair FIFO entries, power of two.
REQ-003 Parameter TIMEOUT, default 64: maximum cycles waiting for iDone (used only under REQ-030).
REQ-004 Clock  in  1: single clock; all state updates on the rising edge.
REQ-005 Reset  in  1: asynchronous, active-low reset.
REQ-006 iWr_En  in  1: push {iOp_A, iOp_B} into the FIFO.
REQ-007 iOp_A, iOp_B  in  WIDTH each: multiplicand and multiplier to enqueue.
REQ-008 oFull  out  1: FIFO holds DEPTH entries.
REQ-009 oOverflow  out  1: sticky flag; a push was attempted while full.
REQ-010 oValid_Data  out  1: request to the multiplier control machine; operands valid.
REQ-011 oOp_A, oOp_B  out  WIDTH each: operands presented to the multiplier datapath.
REQ-012 iDone  in  1: multiplier reports the product is ready.
REQ-013 iProduct  in  2*WIDTH: multiplier result.
REQ-014 oAck  out  1: acknowledge to the multiplier (drives its iAck).
REQ-015 oResult  out  2*WIDTH: last captured product.
REQ-016 oResult_Valid  out  1: one-cycle pulse when oResult updates.
REQ-017 oBusy  out  1: high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, ACK, encoded in registers updated only on Clock.
REQ-019 IDLE -> REQ when the FIFO is non-empty; oOp_A/oOp_B load from the FIFO head on that edge.
REQ-020 In REQ: oValid_Data=1; oOp_A/oOp_B held stable; on iDone=1, capture iProduct into oResult, pulse oResult_Valid next cycle, pop the FIFO, go to ACK.
REQ-021 In ACK: oAck=1, oValid_Data=0; remain until iDone=0, then go to IDLE (four-phase handshake).
REQ-022 Latency: from a push into an empty FIFO while IDLE, oValid_Data rises 2 edges later (write edge, load edge).
REQ-023 Push accepted only when iWr_En=1 and oFull=0 at the sampling edge; a push while full is dropped and sets oOverflow, even if a pop occurs on the same edge.
REQ-024 Push and pop on the same edge with the FIFO not full: both succeed, count unchanged.
REQ-025 Read/write pointers wrap modulo DEPTH; oFull/empty derive from a registered count of width log2(DEPTH)+1.
REQ-026 iDone=1 while IDLE SHALL be ignored; no capture, no ack.
REQ-027 Back-to-back: after ACK -> IDLE with the FIFO non-empty, the next REQ starts after one IDLE cycle.

Reset
REQ-028 Reset=0 SHALL immediately force: state IDLE, FIFO empty, pointers 0, oValid_Data=0, oAck=0, oOp_A=oOp_B=0, oResult=0, oResult_Valid=0, oOverflow=0, oBusy=0, oTimeout=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction and discard all queued operands; no ack is issued.

Configuration
REQ-030 Macro MULT_HOST_TIMEOUT_EN defined: add output oTimeout (1 bit); a counter clears on REQ entry and increments each cycle in REQ; if TIMEOUT cycles elapse without iDone, pop the entry, pulse oTimeout for one cycle, return to IDLE without oAck or oResult update.
REQ-031 Macro not defined: no counter; REQ waits for iDone indefinitely; the oTimeout port is absent.

Verification
REQ-032 Push A=3, B=5; iDone asserted 8 cycles after oValid_Data with iProduct=15 -> oResult=15, one oResult_Valid pulse, oAck high until iDone drops.
REQ-033 Push 5 pairs with no iDone (DEPTH=4) -> oFull=1 after the 4th push, 5th dropped, oOverflow=1; then serve all -> exactly 4 results in order.
REQ-034 Push 0xFFFF x 0xFFFF, iProduct=0xFFFE0001 -> oResult=0xFFFE0001, no truncation.
REQ-035 Reset low during ACK with 2 queued pairs -> all outputs 0 at once; after release, no oValid_Data until a new push.
REQ-036 MULT_HOST_TIMEOUT_EN, TIMEOUT=64, iDone held 0 -> oTimeout pulses 64 cycles after REQ entry, no oAck, next entry served.
REQ-037 iDone pulsed while IDLE with FIFO empty -> no oAck, oResult unchanged at 0.
